// File: rtl/updown_counter_pkg.sv
// Purpose: shared constants and helpers for the up/down counter.
// Latency: n/a (constants and elaboration-time function only).
// Backpressure: n/a.
package updown_counter_pkg;

  // Direction encoding of the 'up' input
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Limit-mode encoding of the 'sat' input
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Bits needed to count 0..p-1. Always at least 1 so PRESCALE=1 still
  // gets a legal (if trivial) register.
  function automatic int prescale_width(input int p);
    return (p <= 1) ? 1 : $clog2(p);
  endfunction

endpackage

// File: rtl/count_prescaler.sv
// Purpose: emits one tick per PRESCALE enabled cycles; holds while en=0.
// Latency: tick is combinational with en on the PRESCALE-th enabled cycle.
// Backpressure: none; en acts as the only throttle.
// Ports: clk, rst (sync, active-high), en (advance), clr (sync clear),
//        tick (step strobe for the counter).
module count_prescaler
  import updown_counter_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = prescale_width(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/updown_counter.sv
// Purpose: up/down counter with wrap or saturate at 0/MAX, load, wrap flag.
// Latency: count and wrap update one cycle after the inputs; at_limit is combinational.
// Backpressure: none; steps only on enabled cycles (every PRESCALE-th with
//   UPDOWN_COUNTER_PRESCALE_EN defined).
// Ports: clk, rst (sync, active-high), en, up, sat, load, load_val[WIDTH],
//        count[WIDTH], at_limit, wrap.
// Optional feature macro: UPDOWN_COUNTER_PRESCALE_EN (prescaler on en).
module updown_counter
  import updown_counter_pkg::*;
#(
  parameter int              WIDTH    = 4,
  parameter longint unsigned MAX      = (64'd1 << WIDTH) - 64'd1,
  parameter int              PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             at_limit,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic step;

`ifdef UPDOWN_COUNTER_PRESCALE_EN
  // Load restarts the prescale period so a loaded value is held for a
  // full period before its first step.
  count_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (load),
    .tick (step)
  );
`else
  logic unused_prescale;
  assign unused_prescale = ^PRESCALE;
  assign step = en;
`endif

  assign at_limit = ((up == DIR_UP)   && (count == MAX_V)) ||
                    ((up == DIR_DOWN) && (count == '0));

  // Priority rst > load > step. wrap flags any step taken at the limit,
  // whether it wrapped around or saturated in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (load) begin
      count <= (load_val > MAX_V) ? MAX_V : load_val;
      wrap  <= 1'b0;
    end else if (step) begin
      wrap <= at_limit;
      if (at_limit) begin
        if (sat == MODE_WRAP) begin
          count <= (up == DIR_UP) ? '0 : MAX_V;
        end
      end else begin
        count <= (up == DIR_UP) ? count + 1'b1 : count - 1'b1;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_updown_counter.sv
// Purpose: scoreboard bench for updown_counter (WIDTH=4, MAX=9).
// Latency: expects count/wrap one cycle after the driven inputs.
// Backpressure: n/a.
module tb_updown_counter;

`ifdef UPDOWN_COUNTER_PRESCALE_EN
  localparam int PS = 3;
`else
  localparam int PS = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b0;
  logic       sat = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;
  logic [3:0] count;
  logic       at_limit;
  logic       wrap;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int    c;
    int    w;
    int    u;
    string nm;
  } exp_t;

  exp_t sb[$];

  // reference model state
  int m_c = 0;
  int m_w = 0;
  int m_ps = 0;

  always #5 clk = ~clk;

  updown_counter #(
    .WIDTH    (4),
    .MAX      (9),
    .PRESCALE (PS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .sat      (sat),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .at_limit (at_limit),
    .wrap     (wrap)
  );

  task automatic model_step(input int r, e, u, s, l, lv);
    int lim;
    if (r != 0) begin
      m_c = 0; m_w = 0; m_ps = 0;
    end else if (l != 0) begin
      m_c = (lv > 9) ? 9 : lv; m_w = 0; m_ps = 0;
    end else if (e != 0) begin
      if (m_ps == PS - 1) begin
        m_ps = 0;
        lim = ((u != 0) && m_c == 9) || ((u == 0) && m_c == 0);
        m_w = lim;
        if (lim != 0) begin
          if (s == 0) m_c = (u != 0) ? 0 : 9;
        end else begin
          m_c = (u != 0) ? m_c + 1 : m_c - 1;
        end
      end else begin
        m_ps = m_ps + 1;
        m_w = 0;
      end
    end else begin
      m_w = 0;
    end
  endtask

  // Drive one cycle. hc/hw >= 0 are hand-computed expectations; -1 takes
  // the reference model's value instead.
  task automatic drive(input int r, e, u, s, l, lv, hc, hw, input string nm);
    exp_t x;
    @(negedge clk);
    rst = 1'(r); en = 1'(e); up = 1'(u); sat = 1'(s); load = 1'(l);
    load_val = 4'(lv);
    model_step(r, e, u, s, l, lv);
    x.c  = (hc >= 0) ? hc : m_c;
    x.w  = (hw >= 0) ? hw : m_w;
    x.u  = u;
    x.nm = nm;
    sb.push_back(x);
  endtask

  // monitor: every cycle the DUT presents a new count/wrap
  initial begin
    exp_t x;
    int   exp_lim;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        exp_lim = ((x.u != 0) && x.c == 9) || ((x.u == 0) && x.c == 0);
        checks++;
        if (int'(count) != x.c) begin
          errors++;
          $display("FAIL %s count got %0d want %0d", x.nm, count, x.c);
        end
        checks++;
        if (int'(wrap) != x.w) begin
          errors++;
          $display("FAIL %s wrap got %0d want %0d", x.nm, wrap, x.w);
        end
        checks++;
        if (int'(at_limit) != exp_lim) begin
          errors++;
          $display("FAIL %s at_limit got %0d want %0d", x.nm, at_limit, exp_lim);
        end
        checks++;
        if (count > 4'd9) begin
          errors++;
          $display("FAIL %s range got %0d want <=9", x.nm, count);
        end
      end
    end
  end

  initial begin
    // reset state
    drive(1, 0, 1, 0, 0, 0, 0, 0, "reset");

`ifndef UPDOWN_COUNTER_PRESCALE_EN
    // count up with wrap: 1..9,0,1,2; wrap only when 0 shows
    for (int i = 1; i <= 12; i++) begin
      drive(0, 1, 1, 0, 0, 0, i % 10, (i == 10) ? 1 : 0, "up_wrap");
    end
    // load 3, count down saturating: 2,1,0 then holds with wrap
    drive(0, 0, 0, 1, 1, 3, 3, 0, "load3");
    drive(0, 1, 0, 1, 0, 0, 2, 0, "down_sat");
    drive(0, 1, 0, 1, 0, 0, 1, 0, "down_sat");
    drive(0, 1, 0, 1, 0, 0, 0, 0, "down_sat");
    drive(0, 1, 0, 1, 0, 0, 0, 1, "sat_hold0");
    drive(0, 1, 0, 1, 0, 0, 0, 1, "sat_hold0");
    // load above MAX clamps; load at limit gives no wrap
    drive(0, 1, 1, 0, 1, 15, 9, 0, "load_clamp");
    drive(0, 1, 1, 0, 0, 0, 0, 1, "wrap_from9");
    // rst beats load and en
    drive(0, 0, 1, 0, 1, 5, 5, 0, "load5");
    drive(1, 1, 1, 0, 1, 7, 0, 0, "rst_prio");
    // saturate at MAX, then direction flip takes effect at once
    drive(0, 0, 1, 1, 1, 9, 9, 0, "load9");
    drive(0, 1, 1, 1, 0, 0, 9, 1, "sat_hold9");
    drive(0, 1, 0, 1, 0, 0, 8, 0, "dir_flip");
    drive(0, 0, 0, 1, 0, 0, 8, 0, "hold");
    // decrement wraps 0 -> MAX
    drive(0, 0, 0, 0, 1, 0, 0, 0, "load0");
    drive(0, 1, 0, 0, 0, 0, 9, 1, "down_wrap");
`else
    // PRESCALE=3: steps on enabled cycles 3, 6, 9
    for (int i = 1; i <= 9; i++) begin
      drive(0, 1, 1, 0, 0, 0, i / 3, 0, "prescale");
    end
    // load clears prescaler; en=0 holds it
    drive(0, 1, 1, 0, 1, 4, 4, 0, "ps_load");
    drive(0, 1, 1, 0, 0, 0, 4, 0, "ps_after_load");
    drive(0, 0, 1, 0, 0, 0, 4, 0, "ps_hold");
    drive(0, 1, 1, 0, 0, 0, 4, 0, "ps_after_load");
    drive(0, 1, 1, 0, 0, 0, 5, 0, "ps_step");
    // reset aborts prescale progress
    drive(0, 1, 1, 0, 0, 0, 5, 0, "ps_part");
    drive(1, 1, 1, 0, 0, 0, 0, 0, "ps_rst");
    drive(0, 1, 1, 0, 0, 0, 0, 0, "ps_post_rst");
    drive(0, 1, 1, 0, 0, 0, 0, 0, "ps_post_rst");
    drive(0, 1, 1, 0, 0, 0, 1, 0, "ps_post_rst");
`endif

    // random traffic against the reference model
    for (int i = 0; i < 10000; i++) begin
      drive(($urandom_range(0, 199) == 0) ? 1 : 0,
            int'($urandom_range(0, 1)),
            int'($urandom_range(0, 1)),
            int'($urandom_range(0, 1)),
            ($urandom_range(0, 9) == 0) ? 1 : 0,
            int'($urandom_range(0, 15)),
            -1, -1, "random");
    end

    @(negedge clk);
    en = 1'b0; load = 1'b0; rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain queue got %0d want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
